uart_rx_frame_ctrl: RTL and testbench

Frame controller that sits on the pop side of the UART receive FIFO (pop/can_pop/data multi-pop interface). It drives `pop` to drain bytes and hunts for a sync byte. It parses a length-prefixed, XOR-checked frame into a payload buffer and presents each good frame on a valid/ready handshake to the command layer. Bad, oversized or stalled frames are discarded and counted.

---
 rtl/uart_rx_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller on the pop side of the UART RX FIFO. It hunts for SYNC, then
// parses LEN, the payload and an XOR check byte, and hands good frames over valid/ready.
module uart_rx_frame_ctrl #(
    parameter int          N           = 4,
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  SYNC        = 8'hA5,
    parameter int          TIMEOUT_CYC = 50000,
    localparam int         PW          = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N-1:0][7:0]         fifo_data,
    input  logic [PW-1:0]             fifo_can_pop,
    output logic [PW-1:0]             fifo_pop,
    output logic [MAX_LEN-1:0][7:0]   frame_data,
    output logic [7:0]                frame_len,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic                      err_chk,
    output logic                      err_len,
    output logic                      err_timeout,
    output logic [15:0]               frame_cnt,
    output logic [15:0]               err_cnt,
    output logic [2:0]                o_dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAY, S_CHK, S_HOLD} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [7:0]               r_rem;
    logic [7:0]               r_idx;
    logic [7:0]               r_acc;
    logic [7:0]               r_len;
    logic [TW-1:0]            r_tmo;
    logic [MAX_LEN-1:0][7:0]  r_frame_data;
    logic [7:0]               r_frame_len;
    logic                     r_frame_valid;
    logic                     r_err_chk;
    logic                     r_err_len;
    logic                     r_err_tmo;
    logic [15:0]              r_frame_cnt;
    logic [15:0]              r_err_cnt;

    logic [PW-1:0]            w_rem_c;
    logic [PW-1:0]            w_k;
    logic [PW-1:0]            w_pop;
    logic                     w_active;
    logic                     w_tmo_hit;
    logic                     w_len_err;
    logic                     w_chk_ok;
    logic                     w_chk_err;
    logic [7:0]               w_xor;
    logic [MAX_LEN-1:0]       w_wr_en;
    logic [MAX_LEN-1:0][7:0]  w_wr_byte;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_HUNT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HUNT: if (w_pop != '0 && fifo_data[0] == SYNC) w_next = S_LEN;
            S_LEN: begin
                if (w_pop != '0) w_next = w_len_err ? S_HUNT : S_PAY;
                else if (w_tmo_hit) w_next = S_HUNT;
            end
            S_PAY: begin
                if (w_pop != '0 && 8'(w_pop) == r_rem) w_next = S_CHK;
                else if (w_tmo_hit) w_next = S_HUNT;
            end
            S_CHK: begin
                if (w_chk_ok) w_next = S_HOLD;
                else if (w_chk_err || w_tmo_hit) w_next = S_HUNT;
            end
            S_HOLD: if (r_frame_valid && frame_ready) w_next = S_HUNT;
            default: w_next = S_HUNT;
        endcase
    end

    // Pop count and the per-cycle decisions; the payload pop is min(can_pop, rem, N).
    always_comb begin
        w_rem_c = (r_rem > 8'(N)) ? PW'(N) : r_rem[PW-1:0];
        w_k     = fifo_can_pop;
        if (w_k > PW'(N)) w_k = PW'(N);
        if (w_k > w_rem_c) w_k = w_rem_c;
        w_pop = '0;
        case (r_state)
            S_HUNT, S_LEN, S_CHK: w_pop = (fifo_can_pop != '0) ? PW'(1) : '0;
            S_PAY:                w_pop = w_k;
            default:              w_pop = '0;
        endcase
        if (!rstn) w_pop = '0;
        w_active  = (r_state == S_LEN) || (r_state == S_PAY) || (r_state == S_CHK);
        w_tmo_hit = w_active && (w_pop == '0) && (r_tmo == TW'(TIMEOUT_CYC - 1));
        w_len_err = (r_state == S_LEN) && (w_pop != '0) &&
                    ((fifo_data[0] == 8'h00) || (fifo_data[0] > 8'(MAX_LEN)));
        w_chk_ok  = (r_state == S_CHK) && (w_pop != '0) && (fifo_data[0] == r_acc);
        w_chk_err = (r_state == S_CHK) && (w_pop != '0) && (fifo_data[0] != r_acc);
        w_xor     = '0;
        w_wr_en   = '0;
        w_wr_byte = '0;
        if (r_state == S_PAY) begin
            for (int i = 0; i < N; i++) begin
                if (PW'(i) < w_pop) begin
                    w_xor = w_xor ^ fifo_data[i];
                    for (int j = 0; j < MAX_LEN; j++) begin
                        if (int'(r_idx) + i == j) begin
                            w_wr_en[j]   = 1'b1;
                            w_wr_byte[j] = fifo_data[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rem         <= '0;
            r_idx         <= '0;
            r_acc         <= '0;
            r_len         <= '0;
            r_tmo         <= '0;
            r_frame_data  <= '0;
            r_frame_len   <= '0;
            r_frame_valid <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_tmo     <= 1'b0;
            r_frame_cnt   <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_err_chk <= w_chk_err;
            r_err_len <= w_len_err;
            r_err_tmo <= w_tmo_hit;
            if ((w_chk_err || w_len_err || w_tmo_hit) && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
            if (w_active && w_pop == '0 && !w_tmo_hit) r_tmo <= r_tmo + TW'(1);
            else                                      r_tmo <= '0;
            if (r_state == S_LEN && w_pop != '0 && !w_len_err) begin
                r_rem <= fifo_data[0];
                r_idx <= '0;
                r_acc <= fifo_data[0];
                r_len <= fifo_data[0];
            end
            if (r_state == S_PAY && w_pop != '0) begin
                r_acc <= r_acc ^ w_xor;
                r_rem <= r_rem - 8'(w_pop);
                r_idx <= r_idx + 8'(w_pop);
            end
            for (int j = 0; j < MAX_LEN; j++)
                if (w_wr_en[j]) r_frame_data[j] <= w_wr_byte[j];
            if (w_chk_ok) begin
                r_frame_len   <= r_len;
                r_frame_valid <= 1'b1;
                if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (r_state == S_HOLD && r_frame_valid && frame_ready) r_frame_valid <= 1'b0;
        end
    end

    assign fifo_pop    = w_pop;
    assign frame_data  = r_frame_data;
    assign frame_len   = r_frame_len;
    assign frame_valid = r_frame_valid;
    assign err_chk     = r_err_chk;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_tmo;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a byte-queue FIFO model feeds the pop side,
// delivered frames are captured and compared against hand-computed expectations.
module tb_uart_rx_frame_ctrl;

    localparam int N       = 4;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;
    localparam int PW      = $clog2(N + 1);

    logic                     clk;
    logic                     rstn;
    logic [N-1:0][7:0]        fifo_data;
    logic [PW-1:0]            fifo_can_pop;
    logic [PW-1:0]            fifo_pop;
    logic [MAX_LEN-1:0][7:0]  frame_data;
    logic [7:0]               frame_len;
    logic                     frame_valid;
    logic                     frame_ready;
    logic                     err_chk;
    logic                     err_len;
    logic                     err_timeout;
    logic [15:0]              frame_cnt;
    logic [15:0]              err_cnt;
    logic [2:0]               o_dbg_state;

    uart_rx_frame_ctrl #(
        .N(N), .MAX_LEN(MAX_LEN), .SYNC(8'hA5), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .fifo_data(fifo_data), .fifo_can_pop(fifo_can_pop), .fifo_pop(fifo_pop),
        .frame_data(frame_data), .frame_len(frame_len),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  fifo_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          lim = 1;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_chk = 0, n_len = 0, n_tmo = 0;
    int          last_pop_cyc = 0, tmo_seen_cyc = 0;
    int          max_pop = 0;
    logic        pop_over = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [87:0] v, input int n);
        for (int k = 0; k < n; k++) fifo_q.push_back(v[87 - 8*k -: 8]);
    endtask

    task automatic check_frames(input string tag);
        int n;
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_frame"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // FIFO model: the pop decided before an edge is removed just after it.
    initial begin
        logic [PW-1:0] pop_s;
        int            nb;
        fifo_can_pop = '0;
        fifo_data    = '0;
        forever begin
            @(negedge clk);
            pop_s = fifo_pop;
            if (pop_s > fifo_can_pop) pop_over = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(pop_s); i++)
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            nb = fifo_q.size();
            if (nb > lim) nb = lim;
            if (nb > N) nb = N;
            fifo_can_pop = PW'(nb);
            for (int i = 0; i < N; i++) fifo_data[i] = (i < fifo_q.size()) ? fifo_q[i] : 8'h00;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn) begin
                if (err_chk) n_chk++;
                if (err_len) n_len++;
                if (err_timeout) begin
                    n_tmo++;
                    if (tmo_seen_cyc == 0) tmo_seen_cyc = cyc;
                end
                if (fifo_pop != '0) last_pop_cyc = cyc;
                if (int'(fifo_pop) > max_pop) max_pop = int'(fifo_pop);
                if (frame_valid && frame_ready)
                    got_q.push_back({frame_len,
                                     (frame_len > 0) ? frame_data[0] : 8'h00,
                                     (frame_len > 1) ? frame_data[1] : 8'h00,
                                     (frame_len > 2) ? frame_data[2] : 8'h00});
            end
        end
    end

    initial begin
        logic [MAX_LEN-1:0][7:0] snap;
        logic                    stable;
        rstn        = 1'b0;
        frame_ready = 1'b1;
        push_bytes({8'h00, 80'h0}, 1);
        cycles(3);
        check_eq("rst_valid", frame_valid, 1'b0);
        check_eq("rst_pop", fifo_pop, 0);
        check_eq("rst_len", frame_len, 0);
        check_eq("rst_data_zero", frame_data == '0, 1'b1);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_state", o_dbg_state, 0);
        rstn = 1'b1;
        cycles(3);

        // checksum = L ^ payload: 03^11^22^33 = 03
        lim = 1;
        push_bytes({48'hA5_03_11_22_33_03, 40'h0}, 6);
        exp_q.push_back(32'h03_11_22_33);
        cycles(15);
        check_frames("t1");
        check_eq("t1_frame_cnt", frame_cnt, 1);
        check_eq("t1_err_cnt", err_cnt, 0);

        lim = 4;
        max_pop = 0;
        push_bytes({48'hA5_03_11_22_33_03, 40'h0}, 6);
        exp_q.push_back(32'h03_11_22_33);
        cycles(12);
        check_frames("t2");
        check_eq("t2_max_pop", max_pop, 3);
        check_eq("t2_frame_cnt", frame_cnt, 2);

        lim = 1;
        push_bytes({40'hA5_02_10_20_31, 48'h0}, 5);
        cycles(12);
        check_frames("t3_bad");
        check_eq("t3_err_chk", n_chk, 1);
        check_eq("t3_err_cnt", err_cnt, 1);
        push_bytes({32'hA5_01_55_54, 56'h0}, 4);
        exp_q.push_back(32'h01_55_00_00);
        cycles(12);
        check_frames("t3_good");
        check_eq("t3_frame_cnt", frame_cnt, 3);

        push_bytes({32'hA5_00_A5_11, 56'h0}, 4);
        cycles(12);
        check_eq("t4_err_len", n_len, 2);
        check_eq("t4_err_cnt", err_cnt, 3);
        check_eq("t4_state_hunt", o_dbg_state, 0);

        tmo_seen_cyc = 0;
        push_bytes({24'hA5_04_01, 64'h0}, 3);
        cycles(40);
        check_eq("t5_tmo_gap", tmo_seen_cyc - last_pop_cyc, TMO + 1);
        check_eq("t5_err_tmo", n_tmo, 1);
        check_eq("t5_err_cnt", err_cnt, 4);
        push_bytes({32'hA5_01_AA_AB, 56'h0}, 4);
        exp_q.push_back(32'h01_AA_00_00);
        cycles(12);
        check_frames("t5_good");
        check_eq("t5_frame_cnt", frame_cnt, 4);

        frame_ready = 1'b0;
        push_bytes(88'hA5_02_01_02_01_00_FF_A5_01_77_76, 11);
        exp_q.push_back(32'h02_01_02_00);
        exp_q.push_back(32'h01_77_00_00);
        cycles(12);
        check_eq("t6_valid", frame_valid, 1'b1);
        check_eq("t6_len", frame_len, 2);
        snap   = frame_data;
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (fifo_pop != '0 || frame_data != snap || !frame_valid || frame_len != 8'd2)
                stable = 1'b0;
        end
        check_eq("t6_hold_stable", stable, 1'b1);
        check_eq("t6_fifo_left", fifo_q.size(), 6);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        cycles(20);
        check_frames("t6");
        check_eq("t6_frame_cnt", frame_cnt, 6);
        check_eq("t6_err_cnt", err_cnt, 4);
        check_eq("err_pulse_sum", n_chk + n_len + n_tmo, int'(err_cnt));
        check_eq("pop_le_can", pop_over, 1'b0);

        frame_ready = 1'b0;
        push_bytes({32'hA5_01_10_11, 56'h0}, 4);
        cycles(12);
        check_eq("t7_valid_before", frame_valid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("t7_valid_async", frame_valid, 1'b0);
        check_eq("t7_len", frame_len, 0);
        check_eq("t7_frame_cnt", frame_cnt, 0);
        check_eq("t7_err_cnt", err_cnt, 0);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
